// File: rtl/switch_debounce_filter_pkg.sv
// rtl/switch_debounce_filter_pkg.sv - shared types and timing constants for switch conditioning
package switch_debounce_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int DEBOUNCE_LIMIT_DEFAULT = 120000;
  localparam int SYNC_STAGES_DEFAULT    = 2;
  localparam int CLK_HZ                 = 12_000_000;

endpackage

// File: rtl/switch_debounce_filter_if.sv
// rtl/switch_debounce_filter_if.sv - raw pin in, debounced level and edge pulses out
interface switch_debounce_filter_if;

  logic i_Switch;
  logic o_Switch;
  logic o_Press;
  logic o_Release;

  modport slave (
    input  i_Switch,
    output o_Switch,
    output o_Press,
    output o_Release
  );

  modport master (
    output i_Switch,
    input  o_Switch,
    input  o_Press,
    input  o_Release
  );

endinterface

// File: rtl/switch_debounce_filter_sync.sv
// rtl/switch_debounce_filter_sync.sv - N-stage metastability synchronizer, async active-low reset to 0
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_D,
  output logic o_Q
);

  logic [STAGES-1:0] r_Chain;

  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "sync_ff_chain: STAGES must be >= 2");
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Chain <= '0;
    end else begin
      r_Chain <= {r_Chain[STAGES-2:0], i_D};
    end
  end

  assign o_Q = r_Chain[STAGES-1];

endmodule

// File: rtl/switch_debounce_filter.sv
// rtl/switch_debounce_filter.sv - synchronizer + counter debounce with registered press/release pulses
// Pulse logic is compiled only when SWITCH_DEBOUNCE_EDGE_PULSE_EN is defined; otherwise pulses tie to 0.
module switch_debounce_filter
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
  input logic                      i_Clk,
  input logic                      i_Rst_n,
  switch_debounce_filter_if.slave  io
);

  localparam int              CW      = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0]   LP_LAST = CW'(DEBOUNCE_LIMIT - 1);

  if (DEBOUNCE_LIMIT < 1 || SYNC_STAGES < 2) begin : g_bad_param
    $fatal(1, "switch_debounce_filter: need DEBOUNCE_LIMIT >= 1 and SYNC_STAGES >= 2");
  end

  logic          w_Sync;
  state_t        r_State;
  state_t        w_State_Next;
  logic [CW-1:0] r_Count;
  logic [CW-1:0] w_Count_Next;
  logic          r_Switch;
  logic          w_Switch_Next;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_D     (io.i_Switch),
    .o_Q     (w_Sync)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State  <= ST_IDLE;
      r_Count  <= '0;
      r_Switch <= 1'b0;
    end else begin
      r_State  <= w_State_Next;
      r_Count  <= w_Count_Next;
      r_Switch <= w_Switch_Next;
    end
  end

  // Any sample matching the current level is a bounce: drop all accumulated credit.
  always_comb begin
    w_State_Next  = r_State;
    w_Count_Next  = r_Count;
    w_Switch_Next = r_Switch;
    case (r_State)
      ST_IDLE: begin
        if (w_Sync != r_Switch) begin
          if (DEBOUNCE_LIMIT == 1) begin
            w_Switch_Next = w_Sync;
          end else begin
            w_State_Next = ST_COUNT;
            w_Count_Next = CW'(1);
          end
        end
      end
      ST_COUNT: begin
        if (w_Sync == r_Switch) begin
          w_State_Next = ST_IDLE;
          w_Count_Next = '0;
        end else if (r_Count == LP_LAST) begin
          w_State_Next  = ST_IDLE;
          w_Count_Next  = '0;
          w_Switch_Next = w_Sync;
        end else begin
          w_Count_Next = r_Count + 1'b1;
        end
      end
      default: begin
        w_State_Next = ST_IDLE;
        w_Count_Next = '0;
      end
    endcase
  end

  assign io.o_Switch = r_Switch;

`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
  logic w_Accept;
  logic r_Press;
  logic r_Release;

  assign w_Accept = (w_Switch_Next != r_Switch);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Press   <= 1'b0;
      r_Release <= 1'b0;
    end else begin
      r_Press   <= w_Accept &  w_Switch_Next;
      r_Release <= w_Accept & ~w_Switch_Next;
    end
  end

  assign io.o_Press   = r_Press;
  assign io.o_Release = r_Release;
`else
  assign io.o_Press   = 1'b0;
  assign io.o_Release = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_filter.sv
// tb/tb_switch_debounce_filter.sv - directed and random checks of switch_debounce_filter against a run-length model
module tb_switch_debounce_filter;
  localparam int LIM = 8;
  localparam int SYN = 2;
`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  switch_debounce_filter_if sw_if ();

  switch_debounce_filter #(
    .DEBOUNCE_LIMIT (LIM),
    .SYNC_STAGES    (SYN)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .io      (sw_if)
  );

  int vectors = 0;
  int errors  = 0;
  bit pin_q[$];
  int run;
  bit e_sw, e_pr, e_rl;
  int n_press, n_rel;
  int rise;

  // The pin reaches the filter SYN samples late; the level flips once LIM
  // consecutive delayed samples disagree with it.
  function automatic void model_reset();
    pin_q.delete();
    for (int i = 0; i < SYN; i++) pin_q.push_back(1'b0);
    run  = 0;
    e_sw = 1'b0;
    e_pr = 1'b0;
    e_rl = 1'b0;
  endfunction

  task automatic check(input string tag, input logic act, input bit exp);
    vectors++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, act, exp);
    end
  endtask

  task automatic check_int(input string tag, input int act, input int exp);
    vectors++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    check("o_Switch", sw_if.o_Switch, e_sw);
    check("o_Press", sw_if.o_Press, e_pr);
    check("o_Release", sw_if.o_Release, e_rl);
  endtask

  task automatic step();
    bit w;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      w = pin_q.pop_front();
      pin_q.push_back(sw_if.i_Switch);
      e_pr = 1'b0;
      e_rl = 1'b0;
      if (w != e_sw) run++;
      else run = 0;
      if (run == LIM) begin
        e_sw = w;
        e_pr = PULSE_EN && w;
        e_rl = PULSE_EN && !w;
        run  = 0;
      end
    end
    #1;
    check_outputs();
    if (sw_if.o_Press === 1'b1) n_press++;
    if (sw_if.o_Release === 1'b1) n_rel++;
  endtask

  task automatic hold(input bit v, input int n);
    sw_if.i_Switch = v;
    repeat (n) step();
  endtask

  task automatic measure_rise(input int maxn);
    rise = -1;
    for (int i = 0; i < maxn; i++) begin
      step();
      if (rise < 0 && sw_if.o_Switch === 1'b1) rise = i + 1;
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    sw_if.i_Switch = 1'b1;
    model_reset();
    n_press = 0;
    n_rel = 0;

    // reset with the pin already high, then the intended power-on press
    repeat (3) step();
    rst_n = 1'b1;
    measure_rise(14);
    check_int("reset_release_rise_edge", rise, SYN + LIM);
    check_int("reset_release_press_count", n_press, int'(PULSE_EN));
    hold(1'b0, 20);

    // clean press
    n_press = 0; n_rel = 0;
    sw_if.i_Switch = 1'b1;
    measure_rise(14);
    check_int("clean_press_rise_edge", rise, SYN + LIM);
    check_int("clean_press_count", n_press, int'(PULSE_EN));
    check_int("clean_press_release_count", n_rel, 0);
    hold(1'b0, 20);

    // bounce 1,0,1,1,0 then held high
    n_press = 0; n_rel = 0;
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1);
    sw_if.i_Switch = 1'b1;
    measure_rise(14);
    check_int("bounce_rise_edge", rise, SYN + LIM);
    check_int("bounce_press_count", n_press, int'(PULSE_EN));
    hold(1'b0, 20);

    // short glitch rejected, full-window pulse accepted
    n_press = 0; n_rel = 0;
    hold(1'b1, LIM - 1);
    hold(1'b0, 20);
    check_int("glitch7_press_count", n_press, 0);
    hold(1'b1, LIM);
    hold(1'b0, 25);
    check_int("glitch8_press_count", n_press, int'(PULSE_EN));
    check_int("glitch8_release_count", n_rel, int'(PULSE_EN));

    // reset while counting restarts the full latency
    sw_if.i_Switch = 1'b1;
    repeat (SYN + 5) step();
    async_reset();
    repeat (2) step();
    rst_n = 1'b1;
    measure_rise(14);
    check_int("midcount_reset_rise_edge", rise, SYN + LIM);

    // asynchronous reset clears a high output immediately
    step();
    async_reset();
    sw_if.i_Switch = 1'b0;
    step();
    rst_n = 1'b1;
    hold(1'b0, 5);

    // random bouncing segments with occasional reset
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
        repeat ($urandom_range(1, 3)) step();
        rst_n = 1'b1;
      end
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
